// File: rtl/vital_threshold_monitor_if.sv
// Bundle of configuration, sample, acknowledge and status signals exchanged
// between a vital-sign source/operator side and the threshold monitor.
interface vital_threshold_monitor_if #(
  parameter int CNT_W = 3
);

  // Thresholds from the configuration unit (lower / upper)
  logic [6:0]       dataP;
  logic [6:0]       dataQ;

  // Sample stream and operator acknowledge
  logic             sampleValid;
  logic [6:0]       sample;
  logic             ack;

  // Registered status back to the system
  logic             warning;
  logic             alarm;
  logic             fault;
  logic             lowFlag;
  logic             highFlag;
  logic [CNT_W-1:0] violCount;

  // Side that supplies thresholds/samples/ack and observes status
  modport master (
    output dataP, dataQ, sampleValid, sample, ack,
    input  warning, alarm, fault, lowFlag, highFlag, violCount
  );

  // The monitor itself
  modport slave (
    input  dataP, dataQ, sampleValid, sample, ack,
    output warning, alarm, fault, lowFlag, highFlag, violCount
  );

endinterface

// File: rtl/vital_threshold_monitor.sv
// Vital-sign threshold monitor.
// Registers the lower/upper thresholds from the configuration unit, checks
// each valid 7-bit sample against the inclusive window [thr_p, thr_q], and
// debounces violations through NORMAL -> WARN -> ALARM. ALARM is sticky until
// the operator acknowledges after enough consecutive in-range samples.
// An inverted window (thr_p > thr_q) forces FAULT from any state.
module vital_threshold_monitor #(
  parameter int VIOL_LIMIT  = 3,  // consecutive violations to reach ALARM (>= 2)
  parameter int CLEAR_LIMIT = 4,  // consecutive in-range samples before ack can clear ALARM (>= 1)
  parameter int CNT_W       = 3   // counter width; 2**CNT_W-1 >= max(VIOL_LIMIT, CLEAR_LIMIT)
) (
  input logic                        clock,
  input logic                        reset,
  vital_threshold_monitor_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_WARN   = 2'd1,
    ST_ALARM  = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] VIOL_LIM = CNT_W'(VIOL_LIMIT);
  localparam logic [CNT_W-1:0] CLR_LIM  = CNT_W'(CLEAR_LIMIT);

  // Registered thresholds: a change on dataP/dataQ takes effect one cycle later
  logic [6:0]       thr_p;
  logic [6:0]       thr_q;

  // FSM state, counters and flags
  state_t           state;
  logic [CNT_W-1:0] viol_cnt;
  logic [CNT_W-1:0] clr_cnt;
  logic             low_flag;
  logic             high_flag;
  logic             warning_q;
  logic             alarm_q;
  logic             fault_q;

  // Next-state values
  state_t           nxt_state;
  logic [CNT_W-1:0] nxt_viol;
  logic [CNT_W-1:0] nxt_clr;
  logic             nxt_low;
  logic             nxt_high;

  // Sample classification against the registered window
  logic             smp_low;
  logic             smp_high;
  logic             smp_viol;
  logic             cfg_bad;
  logic [CNT_W-1:0] viol_inc;
  logic [CNT_W-1:0] clr_inc;

  assign smp_low  = (bus.sample < thr_p);
  assign smp_high = (bus.sample > thr_q);
  assign smp_viol = smp_low | smp_high;
  assign cfg_bad  = (thr_p > thr_q);

  // Saturating increments of the two counters
  assign viol_inc = (viol_cnt == CNT_MAX) ? viol_cnt : viol_cnt + CNT_ONE;
  assign clr_inc  = (clr_cnt  == CNT_MAX) ? clr_cnt  : clr_cnt  + CNT_ONE;

  // Capture thresholds from the configuration unit every cycle
  always_ff @(posedge clock) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    if (reset) begin
      thr_p <= 7'h00;
      thr_q <= 7'h7F;
    end else begin
      thr_p <= bus.dataP;
      thr_q <= bus.dataQ;
    end
  end

  // Next-state logic: fault check, then sample processing, then ack
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    nxt_state = state;
    nxt_viol  = viol_cnt;
    nxt_clr   = clr_cnt;
    nxt_low   = low_flag;
    nxt_high  = high_flag;

    if (cfg_bad) begin
      // Inverted window overrides everything, including a sticky ALARM
      nxt_state = ST_FAULT;
      nxt_viol  = '0;
      nxt_clr   = '0;
      nxt_low   = 1'b0;
      nxt_high  = 1'b0;
    end else if (state == ST_FAULT) begin
      // Window is valid again; the sample in this cycle is not processed
      nxt_state = ST_NORMAL;
      nxt_viol  = '0;
      nxt_clr   = '0;
    end else begin
      if (bus.sampleValid) begin
        nxt_low  = smp_low;
        nxt_high = smp_high;
        if (smp_viol) begin
          nxt_viol = viol_inc;
          nxt_clr  = '0;
        end else begin
          nxt_viol = '0;
          // The clear counter only runs while an alarm is pending
          nxt_clr  = (state == ST_ALARM) ? clr_inc : '0;
        end
      end

      case (state)
        ST_NORMAL: begin
          if (bus.sampleValid && smp_viol) begin
            nxt_state = ST_WARN;
          end
        end
        ST_WARN: begin
          if (bus.sampleValid) begin
            if (!smp_viol) begin
              nxt_state = ST_NORMAL;
            end else if (viol_inc == VIOL_LIM) begin
              nxt_state = ST_ALARM;
            end
          end
        end
        ST_ALARM: begin
          // Ack sees the clear count already updated by this cycle's sample;
          // an early ack is simply dropped.
          if (bus.ack && (nxt_clr >= CLR_LIM)) begin
            nxt_state = ST_NORMAL;
            nxt_viol  = '0;
            nxt_clr   = '0;
          end
        end
        default: begin
          nxt_state = ST_NORMAL;
        end
      endcase
    end
  end

  // FSM register with registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_NORMAL;
      viol_cnt  <= '0;
      clr_cnt   <= '0;
      low_flag  <= 1'b0;
      high_flag <= 1'b0;
      warning_q <= 1'b0;
      alarm_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state     <= nxt_state;
      viol_cnt  <= nxt_viol;
      clr_cnt   <= nxt_clr;
      low_flag  <= nxt_low;
      high_flag <= nxt_high;
      warning_q <= (nxt_state == ST_WARN);
      alarm_q   <= (nxt_state == ST_ALARM);
      fault_q   <= (nxt_state == ST_FAULT);
    end
  end

  assign bus.warning   = warning_q;
  assign bus.alarm     = alarm_q;
  assign bus.fault     = fault_q;
  assign bus.lowFlag   = low_flag;
  assign bus.highFlag  = high_flag;
  assign bus.violCount = viol_cnt;

endmodule

// File: tb/tb_vital_threshold_monitor.sv
// Testbench for vital_threshold_monitor: a directed vector table covering the
// documented scenarios and corner cases, followed by randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_vital_threshold_monitor;

  localparam int VIOL_LIMIT  = 3;
  localparam int CLEAR_LIMIT = 4;
  localparam int CNT_W       = 3;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clock;
  logic reset;

  vital_threshold_monitor_if #(.CNT_W(CNT_W)) bus ();

  vital_threshold_monitor #(
    .VIOL_LIMIT (VIOL_LIMIT),
    .CLEAR_LIMIT(CLEAR_LIMIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Directed vector: inputs for one cycle and the status expected after the edge.
  // exp packs {warning, alarm, fault, lowFlag, highFlag, violCount[2:0]}.
  typedef struct {
    logic       rst;
    logic [6:0] p;
    logic [6:0] q;
    logic       v;
    logic [6:0] s;
    logic       ack;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model
  typedef enum int {M_NORMAL, M_WARN, M_ALARM, M_FAULT} m_state_t;
  m_state_t m_state;
  int       m_thr_p, m_thr_q, m_viol, m_clr;
  bit       m_lo, m_hi;

  function automatic int sat_inc(input int x);
    return (x + 1 > CNT_MAX) ? CNT_MAX : x + 1;
  endfunction

  task automatic model_step(input bit rst, input int p, input int q,
                            input bit v, input int s, input bit ack);
    m_state_t old;
    bit       bad;
    if (rst) begin
      m_state = M_NORMAL;
      m_thr_p = 0;
      m_thr_q = 127;
      m_viol  = 0;
      m_clr   = 0;
      m_lo    = 0;
      m_hi    = 0;
      return;
    end
    old = m_state;
    if (m_thr_p > m_thr_q) begin
      m_state = M_FAULT;
      m_viol = 0; m_clr = 0; m_lo = 0; m_hi = 0;
    end else if (old == M_FAULT) begin
      m_state = M_NORMAL;
      m_viol = 0; m_clr = 0;
    end else begin
      if (v) begin
        m_lo = (s < m_thr_p);
        m_hi = (s > m_thr_q);
        bad  = m_lo || m_hi;
        if (bad) begin
          m_viol = sat_inc(m_viol);
          m_clr  = 0;
        end else begin
          m_viol = 0;
          m_clr  = (old == M_ALARM) ? sat_inc(m_clr) : 0;
        end
        if (old == M_NORMAL && bad) m_state = M_WARN;
        if (old == M_WARN && !bad) m_state = M_NORMAL;
        if (old == M_WARN && bad && m_viol == VIOL_LIMIT) m_state = M_ALARM;
      end
      if (old == M_ALARM && ack && m_clr >= CLEAR_LIMIT) begin
        m_state = M_NORMAL;
        m_viol  = 0;
        m_clr   = 0;
      end
    end
    m_thr_p = p;
    m_thr_q = q;
  endtask

  function automatic logic [7:0] model_exp();
    return {m_state == M_WARN, m_state == M_ALARM, m_state == M_FAULT,
            m_lo, m_hi, 3'(m_viol)};
  endfunction

  function automatic logic [7:0] dut_status();
    return {bus.warning, bus.alarm, bus.fault, bus.lowFlag, bus.highFlag, bus.violCount};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got w/a/f/lo/hi/vc=%b_%b_%b_%b_%b_%0d required %b_%b_%b_%b_%b_%0d",
               name, $time, act[7], act[6], act[5], act[4], act[3], act[2:0],
               exp[7], exp[6], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic apply(input bit rst, input int p, input int q,
                       input bit v, input int s, input bit ack);
    reset           = rst;
    bus.dataP       = 7'(p);
    bus.dataQ       = 7'(q);
    bus.sampleValid = v;
    bus.sample      = 7'(s);
    bus.ack         = ack;
    @(posedge clock);
    #1;
  endtask

  task automatic add(input bit rst, input int p, input int q, input bit v, input int s,
                     input bit ack, input bit w, input bit a, input bit f,
                     input bit lo, input bit hi, input int vc);
    vec_t t;
    t.rst = rst; t.p = 7'(p); t.q = 7'(q); t.v = v; t.s = 7'(s); t.ack = ack;
    t.exp = {w, a, f, lo, hi, 3'(vc)};
    vecs.push_back(t);
  endtask

  initial begin
    int p, q, s, bias;
    bit v, ack, rst;

    //   rst  P    Q   v  smp ack   w  a  f  lo hi vc
    // Reset, then steady in-range samples (thresholds take effect one cycle late)
    add(1, 40, 100, 0,   0, 0,   0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 40, 100, 1,  60, 0,   0, 0, 0, 0, 0, 0);
    // Inclusive boundaries, then just outside each end
    add(0, 40, 100, 1,  40, 0,   0, 0, 0, 0, 0, 0);
    add(0, 40, 100, 1, 100, 0,   0, 0, 0, 0, 0, 0);
    add(0, 40, 100, 1,  39, 0,   1, 0, 0, 1, 0, 1);
    add(0, 40, 100, 1, 101, 0,   1, 0, 0, 0, 1, 2);
    add(0, 40, 100, 1,  60, 0,   0, 0, 0, 0, 0, 0);
    // Debounce to ALARM, ALARM stays on further violations
    add(0, 40, 100, 1, 120, 0,   1, 0, 0, 0, 1, 1);
    add(0, 40, 100, 1, 120, 0,   1, 0, 0, 0, 1, 2);
    add(0, 40, 100, 1, 120, 0,   0, 1, 0, 0, 1, 3);
    add(0, 40, 100, 1, 120, 0,   0, 1, 0, 0, 1, 4);
    // Early ack is dropped and not remembered; later ack clears
    add(0, 40, 100, 1,  60, 0,   0, 1, 0, 0, 0, 0);
    add(0, 40, 100, 1,  60, 0,   0, 1, 0, 0, 0, 0);
    add(0, 40, 100, 0,   0, 1,   0, 1, 0, 0, 0, 0);
    add(0, 40, 100, 1,  60, 0,   0, 1, 0, 0, 0, 0);
    add(0, 40, 100, 1,  60, 0,   0, 1, 0, 0, 0, 0);
    add(0, 40, 100, 0,   0, 1,   0, 0, 0, 0, 0, 0);
    // Same-cycle sample and ack: ack sees the freshly updated clear count
    add(0, 40, 100, 1, 120, 0,   1, 0, 0, 0, 1, 1);
    add(0, 40, 100, 1, 120, 0,   1, 0, 0, 0, 1, 2);
    add(0, 40, 100, 1, 120, 0,   0, 1, 0, 0, 1, 3);
    add(0, 40, 100, 1,  60, 0,   0, 1, 0, 0, 0, 0);
    add(0, 40, 100, 1,  60, 0,   0, 1, 0, 0, 0, 0);
    add(0, 40, 100, 1,  60, 0,   0, 1, 0, 0, 0, 0);
    add(0, 40, 100, 1,  60, 1,   0, 0, 0, 0, 0, 0);
    // Back to ALARM, then invert the window: FAULT two edges later
    add(0, 40, 100, 1, 120, 0,   1, 0, 0, 0, 1, 1);
    add(0, 40, 100, 1, 120, 0,   1, 0, 0, 0, 1, 2);
    add(0, 40, 100, 1, 120, 0,   0, 1, 0, 0, 1, 3);
    add(0, 100, 40, 1,  60, 0,   0, 1, 0, 0, 0, 0);
    add(0, 100, 40, 1,  60, 0,   0, 0, 1, 0, 0, 0);
    add(0, 100, 40, 1, 120, 1,   0, 0, 1, 0, 0, 0);
    add(0, 40, 100, 1, 120, 0,   0, 0, 1, 0, 0, 0);
    add(0, 40, 100, 1, 120, 0,   0, 0, 0, 0, 0, 0);
    add(0, 40, 100, 0,   0, 0,   0, 0, 0, 0, 0, 0);
    // WARN then back to NORMAL, then reset in the middle of WARN
    add(0, 40, 100, 1, 125, 0,   1, 0, 0, 0, 1, 1);
    add(0, 40, 100, 1, 125, 0,   1, 0, 0, 0, 1, 2);
    add(0, 40, 100, 1,  60, 0,   0, 0, 0, 0, 0, 0);
    add(0, 40, 100, 1, 125, 0,   1, 0, 0, 0, 1, 1);
    add(1, 40, 100, 1, 125, 1,   0, 0, 0, 0, 0, 0);
    add(0, 40, 100, 1,  60, 0,   0, 0, 0, 0, 0, 0);
    // Saturation of violCount at its maximum
    add(0, 40, 100, 1,  10, 0,   1, 0, 0, 1, 0, 1);
    add(0, 40, 100, 1,  10, 0,   1, 0, 0, 1, 0, 2);
    add(0, 40, 100, 1,  10, 0,   0, 1, 0, 1, 0, 3);
    for (int i = 4; i <= 9; i++)
      add(0, 40, 100, 1, 10, 0,   0, 1, 0, 1, 0, (i > CNT_MAX) ? CNT_MAX : i);
    // Invalid sample leaves everything unchanged; ack outside ALARM ignored
    add(0, 40, 100, 0, 120, 1,   0, 1, 0, 1, 0, 7);
    add(1, 40, 100, 0,   0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 40, 100, 1,  50, 1,   0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].p, vecs[i].q, vecs[i].v, vecs[i].s, vecs[i].ack);
      check($sformatf("vec%0d", i), dut_status(), vecs[i].exp);
    end

    // Randomized traffic against the behavioural model
    model_step(1, 40, 100, 0, 0, 0);
    apply(1, 40, 100, 0, 0, 0);
    check("rand_reset", dut_status(), model_exp());
    p = 40;
    q = 100;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        p = $urandom_range(0, 80);
        q = p + $urandom_range(0, 127 - p);
        if ($urandom_range(0, 7) == 0) begin
          s = p; p = q; q = s;
        end
      end
      bias = ((i / 25) % 2 == 1) ? 60 : 12;
      if ($urandom_range(0, 99) < bias) s = $urandom_range(0, 127);
      else if (p <= q) s = $urandom_range(p, q);
      else s = $urandom_range(q, p);
      v   = ($urandom_range(0, 9) < 8);
      ack = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 499) == 0);
      model_step(rst, p, q, v, s, ack);
      apply(rst, p, q, v, s, ack);
      check("random", dut_status(), model_exp());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
